ac_entry_ctrl: RTL and testbench
================================

AC_ENTRY_CTRL -- requirements
Module: ac_entry_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 10: one_second pulses without a key press before abandoning entry.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port one_second, input, 1: one-clk-wide pulse, once per second.
REQ-005 SHALL have port key_valid, input, 1: one-clk-wide pulse marking a keypad press.
REQ-006 SHALL have port key, input, 4: keypad code; 0-9 are digits, 10-15 are non-digits.
REQ-007 SHALL have port alarm_button, input, 1: level; commits an alarm entry, or displays the alarm when idle.
REQ-008 SHALL have port time_button, input, 1: level; commits a time entry.
REQ-009 SHALL have ports new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, output, 4 each: entry buffer, wired to both the alarm register and the time counter.
REQ-010 SHALL have port load_new_a, output, 1: one-cycle strobe loading the alarm register.
REQ-011 SHALL have port load_new_c, output, 1: one-cycle strobe loading the time counter.
REQ-012 SHALL have port show_a, output, 1: display selects the alarm time.
REQ-013 SHALL have port show_new_time, output, 1: display selects the entry buffer.
REQ-014 SHALL have port entry_err, output, 1: one-cycle pulse on a rejected commit.

Function
REQ-015 SHALL implement a registered Moore FSM with states IDLE, SHOW_ALARM, ENTRY, COMMIT_A, COMMIT_C; all outputs registered.
REQ-016 IDLE SHALL behave as follows:
- key_valid with key<=9 -> ENTRY; buffer loads {0,0,0,key}; digit count=1; timer=0.
- Otherwise, alarm_button=1 -> SHOW_ALARM.
- time_button SHALL be ignored; non-digit keys SHALL be ignored.
REQ-017 SHALL hold show_a=1 only in SHOW_ALARM; alarm_button=0 -> IDLE; keys SHALL be ignored in SHOW_ALARM.
REQ-018 ENTRY SHALL behave as follows:
- show_new_time=1.
- Digit key: buffer shifts left (ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key); count increments, saturating at 4; timer=0.
- Non-digit key: ignored; timer not cleared.
REQ-019 In ENTRY, the timer SHALL increment on each one_second pulse; on reaching TIMEOUT_S -> IDLE with buffer cleared to 0, no strobe and no error.
REQ-020 In ENTRY, alarm_button=1 -> COMMIT_A; otherwise time_button=1 -> COMMIT_C; alarm SHALL win when both are asserted.
REQ-021 A button and key_valid in the same cycle SHALL commit, dropping the key; a button and a timeout in the same cycle SHALL commit.
REQ-022 Commit validity SHALL require all of the following:
- count==4;
- ms_hr<=2;
- ls_hr<=9, or ls_hr<=3 when ms_hr==2;
- ms_min<=5; ls_min<=9.
REQ-023 COMMIT_A/COMMIT_C SHALL last exactly one cycle, then return to IDLE:
- Valid: pulse load_new_a (resp. load_new_c) for that cycle.
- Invalid: pulse entry_err instead, with no load strobe.
REQ-024 SHALL hold the buffer unchanged from the commit cycle until the next ENTRY start, so consumers sample stable data with the strobe.
REQ-025 SHALL keep load_new_a, load_new_c and entry_err mutually exclusive and never assert any of them for two consecutive cycles.
REQ-026 After a commit returns to IDLE with alarm_button still held, the FSM SHALL enter SHOW_ALARM on the next cycle.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, buffer=0, count=0, timer=0, and all 1-bit outputs to 0, regardless of the current state.
REQ-028 Reset asserted during ENTRY or a COMMIT cycle SHALL abort it with no load strobe produced after release.
REQ-029 After reset release, the first rising edge SHALL evaluate IDLE transitions normally.

Verification
REQ-030 Keys 0,7,3,0 then alarm_button -> buffer 0,7:3,0; load_new_a high exactly one cycle; then IDLE, SHOW_ALARM while the button is held.
REQ-031 Keys 2,4,0,0 then time_button -> entry_err one cycle; no load_new_c; back to IDLE.
REQ-032 Keys 1,2,3,4,5 then time_button -> buffer 2,3:4,5; load_new_c one cycle.
REQ-033 Key 1 then 10 one_second pulses -> IDLE at the 10th pulse; buffer 0; no strobes.
REQ-034 Four digits then alarm_button and time_button in the same cycle -> load_new_a only.
REQ-035 reset=0 mid-entry after 3 digits -> outputs 0 asynchronously, before the next clk edge; no strobe after release.

Source files
------------

// File: rtl/ac_entry_ctrl.sv
// Keypad time/alarm entry controller: collects up to four digits, validates
// them as HH:MM and strobes the alarm register or time counter on commit.
module ac_entry_ctrl #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_a,
    output logic       show_new_time,
    output logic       entry_err
);

    localparam int unsigned DW = 4;
    localparam int unsigned BW = 4 * DW;
    localparam int unsigned CW = 3;
    localparam int unsigned TW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_ALARM,
        S_ENTRY,
        S_COMMIT_A,
        S_COMMIT_C
    } state_t;

    state_t        r_state;
    state_t        w_state;
    logic [BW-1:0] r_buf;
    logic [BW-1:0] w_buf;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer;
    logic [TW-1:0] w_timer_inc;

    logic r_load_a;
    logic r_load_c;
    logic r_show_a;
    logic r_show_new;
    logic r_err;
    logic w_load_a;
    logic w_load_c;
    logic w_show_a;
    logic w_show_new;
    logic w_err;

    logic w_digit;
    logic w_valid;
    logic w_commit;

    logic [DW-1:0] w_ms_hr;
    logic [DW-1:0] w_ls_hr;
    logic [DW-1:0] w_ms_min;
    logic [DW-1:0] w_ls_min;

    assign w_ms_hr  = r_buf[BW-1 -: DW];
    assign w_ls_hr  = r_buf[BW-DW-1 -: DW];
    assign w_ms_min = r_buf[DW+DW-1 -: DW];
    assign w_ls_min = r_buf[DW-1:0];

    // Commit is judged on the buffer as it stands; a key arriving with the button is dropped.
    assign w_valid = (r_count == CW'(4))
                   && (w_ms_hr <= 4'd2)
                   && ((w_ms_hr == 4'd2) ? (w_ls_hr <= 4'd3) : (w_ls_hr <= 4'd9))
                   && (w_ms_min <= 4'd5)
                   && (w_ls_min <= 4'd9);

    assign w_digit     = key_valid && (key <= 4'd9);
    assign w_timer_inc = r_timer + TW'(1);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state  = r_state;
        w_buf    = r_buf;
        w_count  = r_count;
        w_timer  = r_timer;

        case (r_state)
            S_IDLE: begin
                if (w_digit) begin
                    w_state = S_ENTRY;
                    w_buf   = {{(BW-DW){1'b0}}, key};
                    w_count = CW'(1);
                    w_timer = '0;
                end else if (alarm_button) begin
                    w_state = S_SHOW_ALARM;
                end
            end
            S_SHOW_ALARM: begin
                if (!alarm_button) begin
                    w_state = S_IDLE;
                end
            end
            S_ENTRY: begin
                if (alarm_button) begin
                    w_state = S_COMMIT_A;
                end else if (time_button) begin
                    w_state = S_COMMIT_C;
                end else if (w_digit) begin
                    w_buf   = {r_buf[BW-DW-1:0], key};
                    w_timer = '0;
                    if (r_count != CW'(4)) begin
                        w_count = r_count + CW'(1);
                    end
                end else if (one_second) begin
                    if (w_timer_inc == TW'(TIMEOUT_S)) begin
                        w_state = S_IDLE;
                        w_buf   = '0;
                        w_count = '0;
                        w_timer = '0;
                    end else begin
                        w_timer = w_timer_inc;
                    end
                end
            end
            S_COMMIT_A,
            S_COMMIT_C: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_commit   = (w_state == S_COMMIT_A) || (w_state == S_COMMIT_C);
        w_show_a   = (w_state == S_SHOW_ALARM);
        w_show_new = (w_state == S_ENTRY);
        w_load_a   = (w_state == S_COMMIT_A) && w_valid;
        w_load_c   = (w_state == S_COMMIT_C) && w_valid;
        w_err      = w_commit && !w_valid;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_load_a   <= 1'b0;
            r_load_c   <= 1'b0;
            r_show_a   <= 1'b0;
            r_show_new <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_buf      <= w_buf;
            r_count    <= w_count;
            r_timer    <= w_timer;
            r_load_a   <= w_load_a;
            r_load_c   <= w_load_c;
            r_show_a   <= w_show_a;
            r_show_new <= w_show_new;
            r_err      <= w_err;
        end
    end

    assign new_ms_hr     = w_ms_hr;
    assign new_ls_hr     = w_ls_hr;
    assign new_ms_min    = w_ms_min;
    assign new_ls_min    = w_ls_min;
    assign load_new_a    = r_load_a;
    assign load_new_c    = r_load_c;
    assign show_a        = r_show_a;
    assign show_new_time = r_show_new;
    assign entry_err     = r_err;

endmodule

// File: tb/tb_ac_entry_ctrl.sv
// Bench for ac_entry_ctrl: directed scenarios plus random traffic checked
// cycle by cycle against a digit-accumulator model of the entry rules.
module tb_ac_entry_ctrl;

    localparam int unsigned TO = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic [3:0] new_ms_hr;
    logic [3:0] new_ls_hr;
    logic [3:0] new_ms_min;
    logic [3:0] new_ls_min;
    logic       load_new_a;
    logic       load_new_c;
    logic       show_a;
    logic       show_new_time;
    logic       entry_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 showing alarm, 2 entering, 3 alarm commit, 4 time commit.
    int m_mode    = 0;
    int m_buf     = 0;
    int m_presses = 0;
    int m_secs    = 0;
    bit m_ok      = 1'b0;

    ac_entry_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .one_second   (one_second),
        .key_valid    (key_valid),
        .key          (key),
        .alarm_button (alarm_button),
        .time_button  (time_button),
        .new_ms_hr    (new_ms_hr),
        .new_ls_hr    (new_ls_hr),
        .new_ms_min   (new_ms_min),
        .new_ls_min   (new_ls_min),
        .load_new_a   (load_new_a),
        .load_new_c   (load_new_c),
        .show_a       (show_a),
        .show_new_time(show_new_time),
        .entry_err    (entry_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entry is acceptable when at least four digits were typed and they read as a real HH:MM.
    function automatic bit m_valid();
        int hours;
        int mins;
        hours = ((m_buf >> 12) & 15) * 10 + ((m_buf >> 8) & 15);
        mins  = ((m_buf >> 4) & 15) * 10 + (m_buf & 15);
        return (m_presses >= 4) && (hours < 24) && (mins < 60);
    endfunction

    task automatic model_step();
        bit digit;
        digit = key_valid && (int'(key) < 10);
        if (!reset) begin
            m_mode = 0; m_buf = 0; m_presses = 0; m_secs = 0; m_ok = 1'b0;
            return;
        end
        case (m_mode)
            0: begin
                if (digit) begin
                    m_mode = 2; m_buf = int'(key); m_presses = 1; m_secs = 0;
                end else if (alarm_button) begin
                    m_mode = 1;
                end
            end
            1: if (!alarm_button) m_mode = 0;
            2: begin
                if (alarm_button) begin
                    m_ok = m_valid(); m_mode = 3;
                end else if (time_button) begin
                    m_ok = m_valid(); m_mode = 4;
                end else if (digit) begin
                    m_buf = ((m_buf * 16) + int'(key)) % 65536;
                    m_presses++;
                    m_secs = 0;
                end else if (one_second) begin
                    m_secs++;
                    if (m_secs == int'(TO)) begin
                        m_mode = 0; m_buf = 0; m_presses = 0; m_secs = 0;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    function automatic logic [31:0] m_expect();
        logic [15:0] b;
        b = 16'(m_buf);
        return {11'd0, b, (m_mode == 3) && m_ok, (m_mode == 4) && m_ok,
                m_mode == 1, m_mode == 2, (m_mode >= 3) && !m_ok};
    endfunction

    function automatic logic [31:0] dut_obs();
        return {11'd0, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
                load_new_a, load_new_c, show_a, show_new_time, entry_err};
    endfunction

    function automatic logic [31:0] dut_buf();
        return {16'd0, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag, dut_obs(), m_expect());
    endtask

    task automatic press(input int k);
        key_valid = 1'b1;
        key = 4'(k);
        tick("key");
        key_valid = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b0;
        #1;
        model_step();
        check(tag, dut_obs(), 32'd0);
        tick("rst_hold");
        tick("rst_hold");
        reset = 1'b1;
    endtask

    initial begin
        #3;
        check("reset_state", dut_obs(), 32'd0);
        tick("rst");
        tick("rst");
        reset = 1'b1;
        tick("release");

        // 07:30 into the alarm, then button stays held.
        press(0); press(7); press(3); press(0);
        alarm_button = 1'b1;
        tick("r030_commit");
        check("r030_buf", dut_buf(), 32'h0730);
        check("r030_load_a", 32'(load_new_a), 32'd1);
        tick("r030_idle");
        check("r030_strobe_once", 32'(load_new_a), 32'd0);
        tick("r030_show");
        check("r030_show_a", 32'(show_a), 32'd1);
        alarm_button = 1'b0;
        tick("r030_release");

        // 24:00 is not a time.
        press(2); press(4); press(0); press(0);
        time_button = 1'b1;
        tick("r031_commit");
        check("r031_err", 32'(entry_err), 32'd1);
        check("r031_no_load", 32'(load_new_c), 32'd0);
        time_button = 1'b0;
        tick("r031_idle");
        check("r031_err_once", 32'(entry_err), 32'd0);

        // Five digits keep the last four.
        press(1); press(2); press(3); press(4); press(5);
        time_button = 1'b1;
        tick("r032_commit");
        check("r032_buf", dut_buf(), 32'h2345);
        check("r032_load_c", 32'(load_new_c), 32'd1);
        time_button = 1'b0;
        tick("r032_idle");

        // Abandon after TO idle seconds.
        press(1);
        for (int i = 1; i <= int'(TO); i++) begin
            one_second = 1'b1;
            tick("r033_sec");
            one_second = 1'b0;
            if (i == int'(TO) - 1) check("r033_still_entry", 32'(show_new_time), 32'd1);
            if (i == int'(TO)) begin
                check("r033_left_entry", 32'(show_new_time), 32'd0);
                check("r033_buf_clear", dut_buf(), 32'd0);
            end
            tick("r033_gap");
        end

        // Alarm wins when both buttons are pressed together.
        press(1); press(2); press(3); press(4);
        alarm_button = 1'b1;
        time_button = 1'b1;
        tick("r034_commit");
        check("r034_load_a", 32'(load_new_a), 32'd1);
        check("r034_no_load_c", 32'(load_new_c), 32'd0);
        alarm_button = 1'b0;
        time_button = 1'b0;
        tick("r034_idle");

        // Reset in the middle of an entry.
        press(1); press(2); press(3);
        async_reset("r035_async");
        for (int i = 0; i < 3; i++) begin
            tick("r035_after");
            check("r035_no_strobe", 32'({load_new_a, load_new_c, entry_err}), 32'd0);
        end

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            key_valid  = ($urandom % 3) == 0;
            key        = (($urandom % 6) == 0) ? 4'(10 + ($urandom % 6)) : 4'($urandom % 10);
            one_second = ($urandom % 3) == 0;
            if (($urandom % 10) == 0) alarm_button = ~alarm_button;
            if (($urandom % 10) == 0) time_button = ~time_button;
            if (($urandom % 500) == 0) async_reset("rand_async");
            else tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
